alu_shift_sequencer: RTL and testbench



---
 rtl/alu_shift_sequencer.sv | 134 +++++++++++++
 tb/tb_alu_shift_sequencer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/alu_shift_sequencer.sv
// Multi-cycle signed-amount shifter, one position per clock.
// Define ALU_SHIFT_FAST_EN to step four positions per clock while count >= 4.
module alu_shift_sequencer #(
  parameter int WIDTH = 16,
  parameter int AMT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] operand,
  input  logic [AMT_W-1:0] amount,
  input  logic             arith,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FINISH
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] work;
  logic [AMT_W-1:0] cnt;
  logic             goLeft;
  logic             fillArith;
  logic             carryInt;

  logic [AMT_W-1:0] mag;
  logic [WIDTH-1:0] stepWork;
  logic [AMT_W-1:0] stepCnt;
  logic             stepCarry;
  logic             fillBit;
  logic             quad;

  // -16 negates to 5'b10000, which reads as an unsigned 16
  always_comb begin
    mag = amount[AMT_W-1] ? (~amount + 1'b1) : amount;
  end

  always_comb begin
    fillBit   = fillArith & work[WIDTH-1];
    quad      = 1'b0;
`ifdef ALU_SHIFT_FAST_EN
    quad      = (cnt >= AMT_W'(4));
`endif
    stepWork  = work;
    stepCarry = carryInt;
    stepCnt   = cnt;
    if (quad) begin
      stepCnt = cnt - AMT_W'(4);
      if (goLeft) begin
        stepWork  = {work[WIDTH-5:0], 4'b0000};
        stepCarry = work[WIDTH-4];
      end else begin
        stepWork  = {{4{fillBit}}, work[WIDTH-1:4]};
        stepCarry = work[3];
      end
    end else begin
      stepCnt = cnt - AMT_W'(1);
      if (goLeft) begin
        stepWork  = {work[WIDTH-2:0], 1'b0};
        stepCarry = work[WIDTH-1];
      end else begin
        stepWork  = {fillBit, work[WIDTH-1:1]};
        stepCarry = work[0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      work      <= '0;
      cnt       <= '0;
      goLeft    <= 1'b0;
      fillArith <= 1'b0;
      carryInt  <= 1'b0;
      ready     <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      carry     <= 1'b0;
      zero      <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            work      <= operand;
            goLeft    <= ~amount[AMT_W-1];
            cnt       <= mag;
            fillArith <= arith;
            carryInt  <= 1'b0;
            ready     <= 1'b0;
            busy      <= 1'b1;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          if (cnt != '0) begin
            work     <= stepWork;
            carryInt <= stepCarry;
            cnt      <= stepCnt;
          end else begin
            result <= work;
            zero   <= (work == '0);
            carry  <= carryInt;
            done   <= 1'b1;
            state  <= FINISH;
          end
        end
        FINISH: begin
          done  <= 1'b0;
          ready <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_shift_sequencer.sv
// Directed bench for alu_shift_sequencer.
// Hand-computed vectors; latency follows ALU_SHIFT_FAST_EN.
module tb_alu_shift_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] operand;
  logic [4:0]  amount;
  logic        arith;
  logic        ready;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        carry;
  logic        zero;

  int nChecks = 0;
  int nPass   = 0;

  alu_shift_sequencer #(
    .WIDTH(16),
    .AMT_W(5)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .operand(operand),
    .amount (amount),
    .arith  (arith),
    .ready  (ready),
    .busy   (busy),
    .done   (done),
    .result (result),
    .carry  (carry),
    .zero   (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic int latency(input int k);
`ifdef ALU_SHIFT_FAST_EN
    return k / 4 + k % 4 + 1;
`else
    return k + 1;
`endif
  endfunction

  task automatic runOp(input string tag, input logic [15:0] op,
                       input logic [4:0] amt, input logic ar,
                       input logic [15:0] expRes, input logic expC,
                       input int k);
    int lat;
    lat = 0;
    @(negedge clk);
    start   = 1'b1;
    operand = op;
    amount  = amt;
    arith   = ar;
    @(posedge clk);
    #1;
    start   = 1'b0;
    operand = 16'hDEAD;
    amount  = 5'd3;
    arith   = ~ar;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = i;
        break;
      end
    end
    check({tag, " lat"}, 32'(lat), 32'(latency(k)));
    check({tag, " res"}, 32'(result), 32'(expRes));
    check({tag, " carry"}, 32'(carry), 32'(expC));
    check({tag, " zero"}, 32'(zero), 32'(expRes == 16'h0));
    check({tag, " busy"}, 32'({busy, ready}), 32'(2'b10));
    @(posedge clk);
    #1;
    check({tag, " rdy"}, 32'({ready, busy, done}), 32'(3'b100));
  endtask

  initial begin
    int nDone;
    logic [15:0] gotRes;
    rst_n   = 1'b0;
    start   = 1'b0;
    operand = '0;
    amount  = '0;
    arith   = 1'b0;
    #7;
    check("rst rdy", 32'({ready, busy, done}), 32'(3'b100));
    check("rst res", 32'({result, carry, zero}), 32'({16'h0, 1'b0, 1'b1}));
    @(negedge clk);
    rst_n = 1'b1;

    runOp("l4",    16'h00F0, 5'd4,  1'b0, 16'h0F00, 1'b0, 4);
    runOp("ra1",   16'h8001, 5'h1F, 1'b1, 16'hC000, 1'b1, 1);
    runOp("rl1",   16'h8001, 5'h1F, 1'b0, 16'h4000, 1'b1, 1);
    runOp("l1",    16'h8000, 5'd1,  1'b0, 16'h0000, 1'b1, 1);
    runOp("z0",    16'h1234, 5'd0,  1'b0, 16'h1234, 1'b0, 0);
    runOp("ra16",  16'h8000, 5'h10, 1'b1, 16'hFFFF, 1'b1, 16);
    runOp("rl16",  16'h8000, 5'h10, 1'b0, 16'h0000, 1'b1, 16);
    runOp("la5",   16'h1234, 5'd5,  1'b1, 16'h4680, 1'b0, 5);
    runOp("rl5",   16'hF0F0, 5'h1B, 1'b0, 16'h0787, 1'b1, 5);
    runOp("ra5",   16'hF0F0, 5'h1B, 1'b1, 16'hFF87, 1'b1, 5);
    runOp("l15",   16'h0003, 5'd15, 1'b0, 16'h8000, 1'b1, 15);

    // start pulsed mid-operation must be dropped
    nDone  = 0;
    gotRes = '0;
    @(negedge clk);
    start   = 1'b1;
    operand = 16'h0001;
    amount  = 5'd7;
    arith   = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start   = 1'b1;
    operand = 16'h0100;
    amount  = 5'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        nDone++;
        gotRes = result;
      end
    end
    check("ign dones", 32'(nDone), 32'(1));
    check("ign res", 32'(gotRes), 32'(16'h0080));

    // reset mid-operation aborts without a done pulse
    @(negedge clk);
    start   = 1'b1;
    operand = 16'h00FF;
    amount  = 5'd8;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort rdy", 32'({ready, busy, done}), 32'(3'b100));
    check("abort res", 32'({result, carry, zero}), 32'({16'h0, 1'b0, 1'b1}));
    @(negedge clk);
    rst_n = 1'b1;
    nDone = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (done) nDone++;
    end
    check("abort dones", 32'(nDone), 32'(0));
    check("abort idle", 32'({ready, result}), 32'({1'b1, 16'h0}));

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
